// File: rtl/abacus_sample_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// abacus_sample_scheduler : clear -> delay -> count window -> snapshot sequencer
// Revision: 1.0
// ----------------------------------------------------------------------------
module abacus_sample_scheduler #(
  parameter int NUM_UNITS = 2,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic [31:0]          cfg_rdata,
  input  logic                 snapshot_ack,
  output logic [NUM_UNITS-1:0] profiler_enable,
  output logic                 counter_clear,
  output logic                 snapshot_req,
  output logic                 busy,
  output logic                 irq
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_DELAY = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_SNAP  = 3'd4;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_WINDOW = 4'h4;
  localparam logic [3:0] ADDR_DELAY  = 4'h8;
  localparam logic [3:0] ADDR_STATUS = 4'hC;

  logic [2:0]           state_q, state_d;
  logic                 cont_q;
  logic [NUM_UNITS-1:0] mask_cfg_q, mask_q;
  logic [CNT_W-1:0]     window_cfg_q, delay_cfg_q, window_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 stop_pend_q;
  logic                 irq_q, irq_d;
  logic [15:0]          windows_done_q, windows_done_d;

  logic ctrl_wr, window_wr, delay_wr, status_wr;
  logic start_req, stop_req, snap_done;
  logic unused_wdata;

  assign ctrl_wr   = cfg_we && (cfg_addr == ADDR_CTRL);
  assign window_wr = cfg_we && (cfg_addr == ADDR_WINDOW);
  assign delay_wr  = cfg_we && (cfg_addr == ADDR_DELAY);
  assign status_wr = cfg_we && (cfg_addr == ADDR_STATUS);
  assign start_req = ctrl_wr && cfg_wdata[0];
  assign stop_req  = ctrl_wr && cfg_wdata[1];
  assign snap_done = (state_q == ST_SNAP) && snapshot_ack;
  assign unused_wdata = ^cfg_wdata;

  // Counters run down to zero, so a window of W cycles loads W-1 (0 acts as 1).
  function automatic logic [CNT_W-1:0] win_m1(input logic [CNT_W-1:0] w);
    return (w == '0) ? '0 : w - CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_req && !stop_req) state_d = ST_CLEAR;
      ST_CLEAR: begin
        if (stop_req)                state_d = ST_IDLE;
        else if (delay_cfg_q != '0)  state_d = ST_DELAY;
        else                         state_d = ST_RUN;
      end
      ST_DELAY: begin
        if (stop_req)          state_d = ST_IDLE;
        else if (cnt_q == '0)  state_d = ST_RUN;
      end
      ST_RUN:   if (stop_req || cnt_q == '0) state_d = ST_SNAP;
      ST_SNAP: begin
        if (snapshot_ack) begin
          if (cont_q && !stop_pend_q && !stop_req) state_d = ST_CLEAR;
          else                                     state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    counter_clear   = (state_q == ST_CLEAR);
    profiler_enable = (state_q == ST_RUN) ? mask_q : '0;
    snapshot_req    = (state_q == ST_SNAP);
    busy            = (state_q != ST_IDLE);
    irq             = irq_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      ST_CLEAR: cnt_d = (delay_cfg_q != '0) ? delay_cfg_q - CNT_W'(1) : win_m1(window_cfg_q);
      ST_DELAY: cnt_d = (cnt_q == '0) ? win_m1(window_q) : cnt_q - CNT_W'(1);
      ST_RUN:   if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  // A completing snapshot beats a same-cycle software clear of irq.
  always_comb begin
    irq_d          = irq_q;
    windows_done_d = windows_done_q;
    if (snap_done) begin
      irq_d          = 1'b1;
      windows_done_d = windows_done_q + 16'd1;
    end else if (status_wr && cfg_wdata[1]) begin
      irq_d          = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_q         <= 1'b0;
      mask_cfg_q     <= '0;
      mask_q         <= '0;
      window_cfg_q   <= '0;
      delay_cfg_q    <= '0;
      window_q       <= '0;
      cnt_q          <= '0;
      stop_pend_q    <= 1'b0;
      irq_q          <= 1'b0;
      windows_done_q <= '0;
    end else begin
      if (ctrl_wr) begin
        cont_q     <= cfg_wdata[2];
        mask_cfg_q <= cfg_wdata[8 +: NUM_UNITS];
      end
      if (window_wr) window_cfg_q <= cfg_wdata[CNT_W-1:0];
      if (delay_wr)  delay_cfg_q  <= cfg_wdata[CNT_W-1:0];
      if (state_q == ST_CLEAR) begin
        window_q <= window_cfg_q;
        mask_q   <= mask_cfg_q;
      end
      cnt_q <= cnt_d;
      if (state_q == ST_IDLE || state_q == ST_CLEAR || snap_done)
        stop_pend_q <= 1'b0;
      else if (stop_req && (state_q == ST_RUN || state_q == ST_SNAP))
        stop_pend_q <= 1'b1;
      irq_q          <= irq_d;
      windows_done_q <= windows_done_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_CTRL: begin
        cfg_rdata[2]              = cont_q;
        cfg_rdata[8 +: NUM_UNITS] = mask_cfg_q;
      end
      ADDR_WINDOW: cfg_rdata[CNT_W-1:0] = window_cfg_q;
      ADDR_DELAY:  cfg_rdata[CNT_W-1:0] = delay_cfg_q;
      ADDR_STATUS: begin
        cfg_rdata[0]     = (state_q != ST_IDLE);
        cfg_rdata[1]     = irq_q;
        cfg_rdata[31:16] = windows_done_q;
      end
      default: cfg_rdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/abacus_sample_scheduler.md
# abacus_sample_scheduler

Window scheduler for the ABACUS profiling units. It sequences the instruction and cache profilers through clear → optional start delay → fixed-length count window → snapshot handshake, and can repeat that cycle continuously. It drives the profilers' enable inputs, a counter-clear pulse and a snapshot request. It sits between the bus slave's register decode and the profiler blocks, replacing free-running software enable bits.

## Interface
- NUM_UNITS, default 2: number of profiler enable outputs (bit 0 instruction, bit 1 cache).
- CNT_W, default 32: width of the window and delay counters; must be ≤ 32.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- cfg_we  in  1  single-cycle register write strobe from the bus slave.
- cfg_addr  in  4  word offset; only 0x0, 0x4, 0x8 and 0xC decode.
- cfg_wdata  in  32  write data.
- cfg_rdata  out  32  combinational read of the register at cfg_addr; 0 for undecoded offsets.
- snapshot_ack  in  1  consumer has latched counter values.
- profiler_enable  out  NUM_UNITS  per-unit count enable.
- counter_clear  out  1  one-cycle pulse that clears all profiler counters.
- snapshot_req  out  1  level request to latch counters.
- busy  out  1  high in any state other than IDLE.
- irq  out  1  level output equal to the irq_pending bit.

## Operation
Registers:
- 0x0 CTRL
  - bit0 START: write-1 pulse, reads 0.
  - bit1 STOP: write-1 pulse, reads 0.
  - bit2 CONT: continuous mode.
  - bits[8+NUM_UNITS-1:8] UNIT_MASK.
- 0x4 WINDOW: window length in cycles; a value of 0 is treated as 1.
- 0x8 DELAY: cycles spent in DELAY before each window.
- 0xC STATUS (read)
  - bit0 busy.
  - bit1 irq_pending; write 1 to clear.
  - bits[31:16] windows_done, 16-bit, wraps from 0xFFFF to 0.

State machine: IDLE, CLEAR, DELAY, RUN, SNAP.
- IDLE: START moves to CLEAR. START together with STOP in the same write stays in IDLE (STOP wins).
- CLEAR: one cycle.
  - counter_clear is asserted.
  - WINDOW, DELAY and UNIT_MASK are latched into working copies.
  - Next state is DELAY if the latched DELAY ≠ 0, else RUN.
- DELAY: counts latched-DELAY cycles, then moves to RUN. STOP goes straight to IDLE with no snapshot and no irq.
- RUN: profiler_enable = latched UNIT_MASK for exactly latched-WINDOW cycles, then moves to SNAP. STOP truncates the window: profiler_enable drops the next cycle and the next state is SNAP.
- SNAP: snapshot_req is held high until snapshot_ack is sampled high, including an ack in the first SNAP cycle. On the ack cycle:
  - windows_done increments.
  - irq_pending sets.
  - Next state is CLEAR if CONT=1 and no stop is pending, else IDLE.
  - A STOP during SNAP sets stop_pending; the snapshot still completes.
- START while busy is ignored.
- Writes to WINDOW, DELAY or UNIT_MASK while busy take effect at the next CLEAR.
- Clearing irq in the same cycle it sets: set wins.
- Reset mid-operation: all outputs deassert immediately and the FSM returns to IDLE.

## Timing
- Reset values:
  - Outputs: profiler_enable=0, counter_clear=0, snapshot_req=0, busy=0, irq=0.
  - Registers and counters: all 0.
- Write of START sampled at edge T:
  - counter_clear is high for cycle T+1 only.
  - With DELAY=0, profiler_enable is high for cycles T+2 … T+1+W (W = latched WINDOW).
  - snapshot_req rises at T+2+W.
- DELAY=D adds exactly D cycles between CLEAR and RUN.
- Ack sampled at edge A:
  - snapshot_req drops at A+1.
  - irq rises at A+1.
  - The next CLEAR (continuous mode) is at A+1.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs except cfg_rdata.

## Test plan
- WINDOW=5, DELAY=0, MASK=0b11, START, ack tied high → counter_clear 1 cycle; enable 0b11 for exactly 5 cycles; snapshot_req 1 cycle; irq=1; windows_done=1; busy returns 0.
- WINDOW=0, DELAY=3 → 3 DELAY cycles, then exactly 1 enable cycle.
- CONT=1, WINDOW=4, ack delayed 2 cycles → snapshot_req held 3 cycles; CLEAR follows the ack; after 3 windows windows_done=3. STOP mid-RUN → truncated window, snapshot completes, then IDLE.
- STOP during DELAY → IDLE next cycle, no snapshot_req, irq stays 0. START+STOP in one write while IDLE → no action.
- START while RUN → ignored. WINDOW rewritten during RUN → used only by the next window. Write 1 to STATUS bit1 → irq clears.
- Assert rst during SNAP → all outputs 0 at once; STATUS reads 0. Preload windows_done=0xFFFF via 65535 windows (or a force) → the next window wraps it to 0.
